// File: rtl/act_expand_stream.sv
`default_nettype none
// ============================================================================
//  Module      : act_expand_stream
//  Description : Accepts one packed vector of truncated activations. It widens
//                each activation back to WIDTH_IN bits at the pre-truncation
//                scale and streams the results one per cycle, together with an
//                index and a last flag. Both sides use a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module act_expand_stream #(
  parameter int WIDTH_IN   = 8,
  parameter int MSB_OUT    = 4,
  parameter int N_ACT      = 10,
  parameter int ROUND_HALF = 0,
  parameter int IDX_W      = $clog2(N_ACT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  input  logic [N_ACT*MSB_OUT-1:0] vec_data,
  output logic                     act_valid,
  input  logic                     act_ready,
  output logic [WIDTH_IN-1:0]      act_data,
  output logic [IDX_W-1:0]         act_idx,
  output logic                     act_last
);

  localparam int               c_LSB_W    = WIDTH_IN - MSB_OUT;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_ACT - 1);

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_STREAM = 1'b1;

  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic                     r_started;
  logic [N_ACT*MSB_OUT-1:0] r_vec;
  logic [IDX_W-1:0]         r_idx;
  logic [WIDTH_IN-1:0]      r_data;
  logic                     r_last;

  logic                     w_vec_hs;
  logic                     w_act_hs;
  logic [N_ACT*MSB_OUT-1:0] w_sel_vec;
  logic [IDX_W-1:0]         w_sel_idx;
  logic [IDX_W-1:0]         w_idx_inc;
  logic [MSB_OUT-1:0]       w_next_elem;
  logic [WIDTH_IN-1:0]      w_next_word;
  logic                     w_next_last;

  assign w_vec_hs = vec_valid & vec_ready;
  assign w_act_hs = act_valid & act_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);

  // A newly accepted vector always starts at element 0; otherwise step along
  // the held vector.
  assign w_sel_vec   = w_vec_hs ? vec_data : r_vec;
  assign w_sel_idx   = w_vec_hs ? '0 : w_idx_inc;
  assign w_next_elem = w_sel_vec[w_sel_idx*MSB_OUT +: MSB_OUT];
  assign w_next_last = (w_sel_idx == c_LAST_IDX);

  // The truncated LSBs are refilled with zeros or with the interval midpoint.
  generate
    if (c_LSB_W > 0) begin : g_fill
      localparam logic [c_LSB_W-1:0] c_FILL =
        (ROUND_HALF != 0) ? {1'b1, {(c_LSB_W-1){1'b0}}} : '0;
      assign w_next_word = {w_next_elem, c_FILL};
    end else begin : g_nofill
      assign w_next_word = w_next_elem;
    end
  endgenerate

  // State register, plus a flag that keeps vec_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Next state: leave STREAM after the last element unless a new vector lands the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_vec_hs) w_state_nxt = c_ST_STREAM;
      c_ST_STREAM: if (w_act_hs && r_last && !w_vec_hs) w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Handshake outputs; vec_ready in STREAM opens only as the last element leaves.
  always_comb begin
    act_valid = 1'b0;
    vec_ready = 1'b0;
    case (r_state)
      c_ST_IDLE: vec_ready = r_started;
      c_ST_STREAM: begin
        act_valid = 1'b1;
        vec_ready = r_started & act_ready & r_last;
      end
      default: begin
        act_valid = 1'b0;
        vec_ready = 1'b0;
      end
    endcase
  end

  // Vector, index and registered element outputs; they hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_vec_hs) begin
      r_vec  <= vec_data;
      r_idx  <= '0;
      r_data <= w_next_word;
      r_last <= w_next_last;
    end else if (w_act_hs && !r_last) begin
      r_idx  <= w_idx_inc;
      r_data <= w_next_word;
      r_last <= w_next_last;
    end
  end

  assign act_data = r_data;
  assign act_idx  = r_idx;
  assign act_last = r_last;

endmodule
`default_nettype wire
